// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_DATA = 3'd1,
    ST_POLL_RD   = 3'd2,
    ST_POLL_CHK  = 3'd3,
    ST_WRITE     = 3'd4,
    ST_HOLD      = 3'd5
  } state_e;

  // Avalon-MM register map of the UART core
  localparam logic [3:0] UART_ADDR_TXD  = 4'd0;
  localparam logic [3:0] UART_ADDR_STAT = 4'd1;
  // Status register bit meaning "transmit holding register free"
  localparam int         STAT_READY_BIT = 0;

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Round-robin pick of one requester, searching upward from last_i+1 with wrap.
// Latency: combinational.  Backpressure: none; caller decides when to use gnt_o.
// Ports: req_i request vector, last_i index of previous owner, gnt_o one-hot (zero if no request).
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDXW  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDXW-1:0]  last_i,
  output logic [N_REQ-1:0] gnt_o
);

  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  logic [N_REQ-1:0] mask;
  logic [N_REQ-1:0] req_hi;
  logic [N_REQ-1:0] pick;

  // Requests above the last owner win first; otherwise wrap to the lowest index.
  always_comb begin
    mask = '0;
    for (int i = 0; i < N_REQ; i++) begin
      mask[i] = (i > int'(last_i));
    end
    req_hi = req_i & mask;
    pick   = (req_hi != '0) ? req_hi : req_i;
    // isolate lowest set bit
    gnt_o  = pick & (~pick + ONE);
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one Avalon-MM UART transmitter between N_REQ byte streams, packet-atomic round robin.
// Latency: per byte one status read + one write + HOLD_CYC idle cycles; grant one cycle after valid.
// Backpressure: req_ready_o strobes once per accepted byte; requesters hold valid/data until then.
// Ports: clk_i/arst_n_i; req_valid_i/req_data_i/req_last_i/req_ready_o per requester;
//   grant_o one-hot owner; avm_* master to the UART core; stall_err_o timeout pulse; busy_o.
// HOLD_CYC must be at least 1.
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int HOLD_CYC  = 2,
  parameter int STALL_MAX = 1024
) (
  input  logic               clk_i,
  input  logic               arst_n_i,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [8*N_REQ-1:0] req_data_i,
  input  logic [N_REQ-1:0]   req_last_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic [N_REQ-1:0]   grant_o,
  output logic [3:0]         avm_address_o,
  output logic               avm_read_o,
  output logic               avm_write_o,
  output logic [7:0]         avm_writedata_o,
  input  logic [7:0]         avm_readdata_i,
  output logic               stall_err_o,
  output logic               busy_o
);

  localparam int IDXW = $clog2(N_REQ);
  localparam int SCW  = $clog2(STALL_MAX + 1);
  localparam int HCW  = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  state_e           state_q;
  logic [N_REQ-1:0] grant_q;
  logic [IDXW-1:0]  last_q;
  logic [SCW-1:0]   stall_cnt_q;
  logic [HCW-1:0]   hold_cnt_q;
  logic             last_byte_q;
  logic             rd_q;
  logic             wr_q;
  logic [3:0]       addr_q;
  logic [7:0]       wdata_q;
  logic [N_REQ-1:0] ready_q;
  logic             stall_err_q;

  logic [N_REQ-1:0] arb_gnt;
  logic [IDXW-1:0]  grant_idx;
  logic [7:0]       gnt_dat;
  logic             gnt_vld;
  logic             gnt_last;
  logic [SCW-1:0]   stall_cnt_inc;
  logic             unused_rdata;

  rr_arbiter #(.N_REQ(N_REQ), .IDXW(IDXW)) u_arb (
    .req_i  (req_valid_i),
    .last_i (last_q),
    .gnt_o  (arb_gnt)
  );

  // Owner's index and byte-stream signals, selected by the one-hot grant.
  always_comb begin
    grant_idx = '0;
    gnt_dat   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        grant_idx = IDXW'(i);
        gnt_dat   = req_data_i[8*i +: 8];
      end
    end
  end

  assign gnt_vld       = |(req_valid_i & grant_q);
  assign gnt_last      = |(req_last_i & grant_q);
  assign stall_cnt_inc = stall_cnt_q + SCW'(1);
  // only the ready bit of the status register matters
  assign unused_rdata  = ^avm_readdata_i;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      last_q      <= IDXW'(N_REQ - 1);
      stall_cnt_q <= '0;
      hold_cnt_q  <= '0;
      last_byte_q <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= UART_ADDR_TXD;
      wdata_q     <= '0;
      ready_q     <= '0;
      stall_err_q <= 1'b0;
    end else begin
      // Bus strobes and pulses last a single cycle unless re-armed below.
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= UART_ADDR_TXD;
      wdata_q     <= '0;
      ready_q     <= '0;
      stall_err_q <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (|req_valid_i) begin
            grant_q     <= arb_gnt;
            stall_cnt_q <= '0;
            state_q     <= ST_WAIT_DATA;
          end
        end
        ST_WAIT_DATA: begin
          if (gnt_vld) begin
            rd_q    <= 1'b1;
            addr_q  <= UART_ADDR_STAT;
            state_q <= ST_POLL_RD;
          end else if (stall_cnt_inc == SCW'(STALL_MAX)) begin
            stall_err_q <= 1'b1;
            grant_q     <= '0;
            last_q      <= grant_idx;
            stall_cnt_q <= '0;
            state_q     <= ST_IDLE;
          end else begin
            stall_cnt_q <= stall_cnt_inc;
          end
        end
        ST_POLL_RD: begin
          // read is on the bus this cycle; a withdrawn byte abandons the poll
          state_q <= gnt_vld ? ST_POLL_CHK : ST_WAIT_DATA;
        end
        ST_POLL_CHK: begin
          if (!gnt_vld) begin
            state_q <= ST_WAIT_DATA;
          end else if (avm_readdata_i[STAT_READY_BIT]) begin
            wr_q        <= 1'b1;
            addr_q      <= UART_ADDR_TXD;
            wdata_q     <= gnt_dat;
            ready_q     <= grant_q;
            last_byte_q <= gnt_last;
            state_q     <= ST_WRITE;
          end else begin
            rd_q    <= 1'b1;
            addr_q  <= UART_ADDR_STAT;
            state_q <= ST_POLL_RD;
          end
        end
        ST_WRITE: begin
          stall_cnt_q <= '0;
          hold_cnt_q  <= '0;
          state_q     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (hold_cnt_q == HCW'(HOLD_CYC - 1)) begin
            if (last_byte_q) begin
              grant_q <= '0;
              last_q  <= grant_idx;
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_WAIT_DATA;
            end
          end else begin
            hold_cnt_q <= hold_cnt_q + HCW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign grant_o         = grant_q;
  assign req_ready_o     = ready_q;
  assign avm_read_o      = rd_q;
  assign avm_write_o     = wr_q;
  assign avm_address_o   = addr_q;
  assign avm_writedata_o = wdata_q;
  assign stall_err_o     = stall_err_q;
  assign busy_o          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: requester FIFOs, status responder and bus monitor
// run on the falling edge; scenarios come from a vector table plus hand-written sequences.
module tb_uart_tx_sched;

  localparam int N = 4;

  logic           clk_i;
  logic           arst_n_i;
  logic [N-1:0]   req_valid_i;
  logic [8*N-1:0] req_data_i;
  logic [N-1:0]   req_last_i;
  logic [N-1:0]   req_ready_o;
  logic [N-1:0]   grant_o;
  logic [3:0]     avm_address_o;
  logic           avm_read_o;
  logic           avm_write_o;
  logic [7:0]     avm_writedata_o;
  logic [7:0]     avm_readdata_i;
  logic           stall_err_o;
  logic           busy_o;

  uart_tx_sched #(.N_REQ(N), .HOLD_CYC(2), .STALL_MAX(16)) dut (
    .clk_i           (clk_i),
    .arst_n_i        (arst_n_i),
    .req_valid_i     (req_valid_i),
    .req_data_i      (req_data_i),
    .req_last_i      (req_last_i),
    .req_ready_o     (req_ready_o),
    .grant_o         (grant_o),
    .avm_address_o   (avm_address_o),
    .avm_read_o      (avm_read_o),
    .avm_write_o     (avm_write_o),
    .avm_writedata_o (avm_writedata_o),
    .avm_readdata_i  (avm_readdata_i),
    .stall_err_o     (stall_err_o),
    .busy_o          (busy_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // requester byte FIFOs: {last, byte}
  logic [8:0] fifo [N][16];
  int         head [N];
  int         tail [N];
  int         busy_polls = 0;
  int         rd_cnt = 0;
  int         wr_cnt = 0;
  int         rdy_cnt = 0;
  int         err_pulses = 0;
  logic [7:0] wr_dat [32];
  logic [3:0] wr_gnt [32];
  logic       rd_prev;

  task automatic push(input int rq, input logic [7:0] b, input logic last);
    fifo[rq][tail[rq] % 16] = {last, b};
    tail[rq]++;
  endtask

  task automatic clear_log();
    rd_cnt = 0; wr_cnt = 0; rdy_cnt = 0; err_pulses = 0;
  endtask

  function automatic bit fifos_empty();
    for (int i = 0; i < N; i++) if (head[i] != tail[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input string name, input int limit);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < limit) begin
      @(negedge clk_i);
      n++;
      done = !busy_o && fifos_empty();
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s: still busy after %0d cycles, required idle", name, limit);
    end
  endtask

  // Monitor, status responder and requester driver, all on the falling edge.
  initial begin
    req_valid_i = '0; req_last_i = '0; req_data_i = '0;
    avm_readdata_i = '0; rd_prev = 1'b0;
    forever begin
      @(negedge clk_i);
      if (arst_n_i === 1'b1) begin
        if (avm_read_o) rd_cnt++;
        if (avm_write_o) begin
          if (wr_cnt < 32) begin
            wr_dat[wr_cnt] = avm_writedata_o;
            wr_gnt[wr_cnt] = grant_o;
          end
          wr_cnt++;
          check("wr_addr", 32'(avm_address_o), 32'h0);
          check("wr_ready_is_grant", 32'(req_ready_o), 32'(grant_o));
        end
        if (avm_read_o) check("rd_addr", 32'(avm_address_o), 32'h1);
        if (!avm_read_o && !avm_write_o) check("addr_idle", 32'(avm_address_o), 32'h0);
        check("rd_wr_exclusive", 32'(avm_read_o & avm_write_o), 32'h0);
        check("ready_granted_only", 32'(req_ready_o & ~grant_o), 32'h0);
        rdy_cnt += $countones(req_ready_o);
        if (stall_err_o) err_pulses++;
      end
      // read data is valid the cycle after the strobe, garbage-free zero afterwards
      if (avm_read_o) begin
        if (busy_polls > 0) begin
          avm_readdata_i = 8'h00;
          busy_polls--;
        end else begin
          avm_readdata_i = 8'h01;
        end
      end else if (!rd_prev) begin
        avm_readdata_i = 8'h00;
      end
      rd_prev = avm_read_o;
      for (int i = 0; i < N; i++) begin
        if (req_ready_o[i] && head[i] != tail[i]) head[i]++;
        if (head[i] != tail[i]) begin
          req_valid_i[i] = 1'b1;
          {req_last_i[i], req_data_i[8*i +: 8]} = fifo[i][head[i] % 16];
        end else begin
          req_valid_i[i] = 1'b0;
          req_last_i[i]  = 1'b0;
          req_data_i[8*i +: 8] = 8'h00;
        end
      end
    end
  end

  typedef struct {
    int              rq;
    int              nbytes;
    logic [2:0][7:0] dat;
    int              busy;
    int              exp_writes;
    int              exp_reads;
    int              exp_rdy;
    logic [2:0][7:0] exp_dat;
    logic [3:0]      exp_gnt;
  } vec_t;

  vec_t       tbl [4];
  logic [7:0] exp_d [6];
  logic [3:0] exp_g [6];

  initial begin
    int n;
    bit seen;

    tbl[0] = '{rq:0, nbytes:3, dat:{8'h0A, 8'h69, 8'h48}, busy:0,
               exp_writes:3, exp_reads:3, exp_rdy:3, exp_dat:{8'h0A, 8'h69, 8'h48}, exp_gnt:4'b0001};
    tbl[1] = '{rq:1, nbytes:1, dat:{8'h00, 8'h00, 8'h55}, busy:5,
               exp_writes:1, exp_reads:6, exp_rdy:1, exp_dat:{8'h00, 8'h00, 8'h55}, exp_gnt:4'b0010};
    tbl[2] = '{rq:3, nbytes:2, dat:{8'h00, 8'h5A, 8'hA5}, busy:1,
               exp_writes:2, exp_reads:3, exp_rdy:2, exp_dat:{8'h00, 8'h5A, 8'hA5}, exp_gnt:4'b1000};
    tbl[3] = '{rq:2, nbytes:1, dat:{8'h00, 8'h00, 8'hFF}, busy:0,
               exp_writes:1, exp_reads:1, exp_rdy:1, exp_dat:{8'h00, 8'h00, 8'hFF}, exp_gnt:4'b0100};

    arst_n_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("reset_outputs", 32'({grant_o, req_ready_o, avm_read_o, avm_write_o, avm_address_o,
                                avm_writedata_o, stall_err_o, busy_o}), 32'h0);
    arst_n_i = 1'b1;
    @(negedge clk_i);

    // Contention: r0 (two packets) and r2 (one packet) valid together after reset.
    clear_log();
    push(0, 8'hA0, 1'b0); push(0, 8'hA1, 1'b1); push(0, 8'hA2, 1'b0); push(0, 8'hA3, 1'b1);
    push(2, 8'hC0, 1'b0); push(2, 8'hC1, 1'b1);
    wait_idle("rr_contention", 1000);
    exp_d = '{8'hA0, 8'hA1, 8'hC0, 8'hC1, 8'hA2, 8'hA3};
    exp_g = '{4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b0001, 4'b0001};
    check("rr_write_count", wr_cnt, 6);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("rr_data%0d", k), 32'(wr_dat[k]), 32'(exp_d[k]));
      check($sformatf("rr_grant%0d", k), 32'(wr_gnt[k]), 32'(exp_g[k]));
    end

    // Single-requester packets from the vector table.
    for (int t = 0; t < 4; t++) begin
      clear_log();
      busy_polls = tbl[t].busy;
      for (int k = 0; k < tbl[t].nbytes; k++)
        push(tbl[t].rq, tbl[t].dat[k], k == tbl[t].nbytes - 1);
      wait_idle($sformatf("v%0d_idle", t), 500);
      check($sformatf("v%0d_writes", t), wr_cnt, tbl[t].exp_writes);
      check($sformatf("v%0d_reads", t), rd_cnt, tbl[t].exp_reads);
      check($sformatf("v%0d_ready_pulses", t), rdy_cnt, tbl[t].exp_rdy);
      for (int k = 0; k < tbl[t].exp_writes; k++) begin
        check($sformatf("v%0d_data%0d", t, k), 32'(wr_dat[k]), 32'(tbl[t].exp_dat[k]));
        check($sformatf("v%0d_grant%0d", t, k), 32'(wr_gnt[k]), 32'(tbl[t].exp_gnt));
      end
      check($sformatf("v%0d_grant_released", t), 32'(grant_o), 32'h0);
    end

    // Stall: r1 sends one non-final byte then goes quiet; r2 waits behind it.
    clear_log();
    push(1, 8'h11, 1'b0);
    n = 0;
    while (grant_o !== 4'b0010 && n < 50) begin @(negedge clk_i); n++; end
    check("stall_granted_r1", 32'(grant_o), 32'h2);
    push(2, 8'h22, 1'b1);
    n = 0;
    while (req_ready_o[1] !== 1'b1 && n < 50) begin @(negedge clk_i); n++; end
    check("stall_first_byte_taken", 32'(req_ready_o[1]), 32'h1);
    // 1 write cycle + 2 hold cycles + 16 stalled cycles, then the registered pulse
    n = 0;
    seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk_i);
      n++;
      seen = stall_err_o;
    end
    check("stall_delay", n, 19);
    check("stall_grant_cleared", 32'(grant_o), 32'h0);
    wait_idle("stall_idle", 500);
    check("stall_pulse_count", err_pulses, 1);
    check("stall_write_count", wr_cnt, 2);
    check("stall_next_data", 32'(wr_dat[1]), 32'h22);
    check("stall_next_grant", 32'(wr_gnt[1]), 32'h4);

    // Reset during POLL_CHK of r2, with polls held busy.
    clear_log();
    busy_polls = 3;
    push(2, 8'h33, 1'b1);
    n = 0;
    while (avm_read_o !== 1'b1 && n < 50) begin @(negedge clk_i); n++; end
    check("rst_saw_poll", 32'(avm_read_o), 32'h1);
    @(negedge clk_i);
    arst_n_i = 1'b0;
    for (int i = 0; i < N; i++) head[i] = tail[i];
    busy_polls = 0;
    #1;
    check("rst_outputs_async", 32'({grant_o, req_ready_o, avm_read_o, avm_write_o, avm_address_o,
                                    avm_writedata_o, stall_err_o, busy_o}), 32'h0);
    check("rst_no_write_before", wr_cnt, 0);
    repeat (2) @(negedge clk_i);
    check("rst_outputs_held", 32'({grant_o, req_ready_o, avm_read_o, avm_write_o, avm_address_o,
                                   avm_writedata_o, stall_err_o, busy_o}), 32'h0);
    clear_log();
    arst_n_i = 1'b1;
    repeat (6) @(negedge clk_i);
    check("rst_no_bus_after", rd_cnt + wr_cnt, 0);
    check("rst_idle_grant", 32'(grant_o), 32'h0);
    push(1, 8'h44, 1'b1);
    push(0, 8'h55, 1'b1);
    wait_idle("rst_resume", 500);
    check("rst_resume_writes", wr_cnt, 2);
    check("rst_first_grant", 32'(wr_gnt[0]), 32'h1);
    check("rst_first_data", 32'(wr_dat[0]), 32'h55);
    check("rst_second_grant", 32'(wr_gnt[1]), 32'h2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter N_REQ, default 4, SHALL be the number of byte-stream requesters sharing the UART transmitter (range 2..8).
REQ-002 Parameter HOLD_CYC, default 2, SHALL be the number of idle cycles after each data write before status polling resumes.
REQ-003 Parameter STALL_MAX, default 1024, SHALL be the number of consecutive cycles a granted requester may withhold valid mid-packet before its grant is revoked.
REQ-004 clk_i  in  1  clock; all logic rising-edge.
REQ-005 arst_n_i  in  1  reset, asynchronous, active-low.
REQ-006 req_valid_i  in  N_REQ  per-requester byte valid.
REQ-007 req_data_i  in  8*N_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-008 req_last_i  in  N_REQ  marks the final byte of a packet.
REQ-009 req_ready_o  out  N_REQ  one-cycle byte acceptance strobe.
REQ-010 grant_o  out  N_REQ  one-hot owner of the transmitter; all-zero when idle.
REQ-011 avm_address_o  out  4  Avalon-MM master address to the UART core.
REQ-012 avm_read_o / avm_write_o  out  1 each  Avalon-MM read / write strobes.
REQ-013 avm_writedata_o  out  8  byte written to the UART core.
REQ-014 avm_readdata_i  in  8  UART core read data, valid exactly one cycle after the read strobe.
REQ-015 stall_err_o  out  1  one-cycle pulse on grant revocation by stall timeout.
REQ-016 busy_o  out  1  high whenever the FSM is not in IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, WAIT_DATA, POLL_RD, POLL_CHK, WRITE, HOLD.
REQ-018 In IDLE, if any req_valid_i is high, the block SHALL grant the first valid requester searching from (last_grant+1) mod N_REQ, register grant_o, and enter WAIT_DATA on the next cycle.
REQ-019 In WAIT_DATA, a high req_valid_i from the granted requester SHALL move the FSM to POLL_RD; otherwise the stall counter SHALL increment.
REQ-020 POLL_RD SHALL assert avm_read_o for exactly one cycle with address 1 (status), then enter POLL_CHK.
REQ-021 POLL_CHK SHALL sample avm_readdata_i[0] (tx ready): 1 enters WRITE, 0 returns to POLL_RD.
REQ-022 WRITE SHALL assert avm_write_o for one cycle with address 0 and avm_writedata_o equal to the granted requester's byte, and SHALL assert req_ready_o of that requester in the same cycle.
REQ-023 After WRITE the FSM SHALL enter HOLD for HOLD_CYC cycles; it then enters IDLE (grant released, last_grant updated) if the written byte had req_last_i high, else WAIT_DATA.
REQ-024 The grant SHALL NOT change between packet start and the write of the last byte except by stall timeout.
REQ-025 If the stall counter reaches STALL_MAX in WAIT_DATA, the block SHALL pulse stall_err_o, clear grant_o, update last_grant and enter IDLE.
REQ-026 The stall counter SHALL clear on every WRITE and on every grant; its width SHALL be clog2(STALL_MAX+1).
REQ-027 avm_read_o and avm_write_o SHALL never be high in the same cycle; address SHALL be 0 whenever neither is high.
REQ-028 req_ready_o SHALL be zero for every non-granted requester at all times.
REQ-029 Requester valid deassertion during POLL_RD/POLL_CHK SHALL return the FSM to WAIT_DATA without writing.
REQ-030 Round-robin pointer SHALL wrap from N_REQ-1 to 0.

Reset
REQ-031 On arst_n_i low: FSM IDLE; grant_o, req_ready_o, avm_read_o, avm_write_o, avm_address_o, avm_writedata_o, stall_err_o, busy_o all zero; counters zero; last_grant = N_REQ-1 so requester 0 has first priority.
REQ-032 Reset mid-packet SHALL abort without any further bus access after release.

Structure
REQ-033 Package uart_sched_pkg SHALL hold the FSM state enum, UART_ADDR_TXD=0, UART_ADDR_STAT=1, STAT_READY_BIT=0.
REQ-034 The round-robin search SHALL be a sub-module rr_arbiter (request vector, last-grant pointer in; one-hot grant out).

Verification
REQ-035 Single requester 0 sends 3 bytes 0x48,0x69,0x0A (last on 0x0A), status ready always 1 -> three writes to address 0 with those values, each preceded by one status read, grant released after 0x0A.
REQ-036 Requesters 0 and 2 both valid from reset, 2-byte packets -> packet of 0 fully written before any byte of 2; next contention grants 2 before 0.
REQ-037 Status returns 0x00 for 5 polls then 0x01 -> exactly 6 reads, then one write; req_ready_o pulses once.
REQ-038 Granted requester drops valid after first byte, STALL_MAX=16 -> stall_err_o pulses once after 16 cycles, grant_o goes 0, next requester served.
REQ-039 arst_n_i asserted during POLL_CHK -> all outputs zero within the reset, no write issued, requester 0 granted first after release.
